// File: rtl/nv_nvdla_cdma_img_rsp_unpack.sv
// CDMA image response unpacker: pairs FIFO contexts with DMA beats, tags idx/last/eol.
// Optional orphan-response watchdog under NVDLA_CDMA_IMG_RSP_ORPHAN_CHK_EN.
module nv_nvdla_cdma_img_rsp_unpack #(
    parameter int DW        = 64,
    parameter int ORPHAN_TO = 16
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          ctx_req,
    output logic          ctx_ready,
    input  logic [10:0]   ctx_data,
    input  logic          dma_rsp_valid,
    output logic          dma_rsp_ready,
    input  logic [DW-1:0] dma_rsp_pd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_pd,
    output logic [4:0]    out_idx,
    output logic          out_last,
    output logic          out_eol,
    output logic          orphan_err
);

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e        state_q, state_d;
    logic          eol_q, eol_d;
    logic [4:0]    nbeat_m1_q, nbeat_m1_d;
    logic [4:0]    start_idx_q, start_idx_d;
    logic [4:0]    beat_cnt_q, beat_cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_pd_q, out_pd_d;
    logic [4:0]    out_idx_q, out_idx_d;
    logic          out_last_q, out_last_d;
    logic          out_eol_q, out_eol_d;

    logic rsp_acc;
    logic beat_last;
    logic last_acc;
    logic pop;

    // State register
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a pop always wins so back-to-back contexts stay ACTIVE
    always_comb begin
        state_d = state_q;
        if (pop) begin
            state_d = ACTIVE;
        end else if (last_acc) begin
            state_d = IDLE;
        end
    end

    // Handshake outputs
    always_comb begin
        dma_rsp_ready = 1'b0;
        unique case (state_q)
            IDLE:    dma_rsp_ready = 1'b0;
            ACTIVE:  dma_rsp_ready = !out_valid_q || out_ready;
            default: dma_rsp_ready = 1'b0;
        endcase
    end

    assign rsp_acc   = dma_rsp_valid && dma_rsp_ready;
    assign beat_last = (beat_cnt_q == nbeat_m1_q);
    assign last_acc  = rsp_acc && beat_last;
    assign ctx_ready = (state_q == IDLE) || last_acc;
    assign pop       = ctx_req && ctx_ready;

    always_comb begin
        eol_d       = eol_q;
        nbeat_m1_d  = nbeat_m1_q;
        start_idx_d = start_idx_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_pd_d    = out_pd_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_eol_d   = out_eol_q;
        if (rsp_acc) begin
            out_valid_d = 1'b1;
            out_pd_d    = dma_rsp_pd;
            out_idx_d   = start_idx_q + beat_cnt_q;
            out_last_d  = beat_last;
            out_eol_d   = eol_q && beat_last;
            beat_cnt_d  = beat_cnt_q + 5'd1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        // Pop after the accept so the new context restarts its own count
        if (pop) begin
            eol_d       = ctx_data[10];
            nbeat_m1_d  = ctx_data[9:5];
            start_idx_d = ctx_data[4:0];
            beat_cnt_d  = 5'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            eol_q       <= 1'b0;
            nbeat_m1_q  <= 5'd0;
            start_idx_q <= 5'd0;
            beat_cnt_q  <= 5'd0;
            out_valid_q <= 1'b0;
            out_pd_q    <= '0;
            out_idx_q   <= 5'd0;
            out_last_q  <= 1'b0;
            out_eol_q   <= 1'b0;
        end else begin
            eol_q       <= eol_d;
            nbeat_m1_q  <= nbeat_m1_d;
            start_idx_q <= start_idx_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_pd_q    <= out_pd_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_eol_q   <= out_eol_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pd    = out_pd_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_eol   = out_eol_q;

`ifdef NVDLA_CDMA_IMG_RSP_ORPHAN_CHK_EN
    localparam logic [4:0] ORPHAN_TO5 = 5'(ORPHAN_TO);

    logic [4:0] idle_cnt_q, idle_cnt_d;
    logic       orphan_q, orphan_d;

    // Saturating so a long orphan stall cannot wrap past the threshold
    always_comb begin
        idle_cnt_d = 5'd0;
        if (state_q == IDLE && dma_rsp_valid && !ctx_req) begin
            idle_cnt_d = (idle_cnt_q == 5'd31) ? idle_cnt_q : idle_cnt_q + 5'd1;
        end
        orphan_d = orphan_q || (idle_cnt_q == ORPHAN_TO5);
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            idle_cnt_q <= 5'd0;
            orphan_q   <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            orphan_q   <= orphan_d;
        end
    end

    assign orphan_err = orphan_q;
`else
    assign orphan_err = 1'b0;
`endif

endmodule

// File: tb/tb_nv_nvdla_cdma_img_rsp_unpack.sv
// Directed bench for nv_nvdla_cdma_img_rsp_unpack: vector table plus wrap/reset/orphan sequences.
module tb_nv_nvdla_cdma_img_rsp_unpack;

    logic        clk;
    logic        reset_;
    logic        ctx_req;
    logic        ctx_ready;
    logic [10:0] ctx_data;
    logic        dma_rsp_valid;
    logic        dma_rsp_ready;
    logic [63:0] dma_rsp_pd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pd;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        out_eol;
    logic        orphan_err;

    int tests;
    int fails;

    nv_nvdla_cdma_img_rsp_unpack #(.DW(64), .ORPHAN_TO(16)) dut (
        .clk           (clk),
        .reset_        (reset_),
        .ctx_req       (ctx_req),
        .ctx_ready     (ctx_ready),
        .ctx_data      (ctx_data),
        .dma_rsp_valid (dma_rsp_valid),
        .dma_rsp_ready (dma_rsp_ready),
        .dma_rsp_pd    (dma_rsp_pd),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pd        (out_pd),
        .out_idx       (out_idx),
        .out_last      (out_last),
        .out_eol       (out_eol),
        .orphan_err    (orphan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [10:0] cd;
        logic        rv;
        logic [63:0] pd;
        logic        ordy;
        logic        e_cr;
        logic        e_rr;
        logic        e_ov;
        logic [4:0]  e_idx;
        logic        e_last;
        logic        e_eol;
        logic [63:0] e_pd;
    } vec_t;

    vec_t vt[$];

    function automatic logic [10:0] cdat(logic e, logic [4:0] n, logic [4:0] s);
        return {e, n, s};
    endfunction

    function automatic vec_t mk(logic req, logic [10:0] cd, logic rv,
                                logic [63:0] pd, logic ordy, logic cr,
                                logic rr, logic ov, logic [4:0] idx,
                                logic last, logic eol, logic [63:0] epd);
        vec_t v;
        v.req = req;  v.cd = cd;  v.rv = rv;  v.pd = pd;  v.ordy = ordy;
        v.e_cr = cr;  v.e_rr = rr;  v.e_ov = ov;  v.e_idx = idx;
        v.e_last = last;  v.e_eol = eol;  v.e_pd = epd;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic req, logic [10:0] cd, logic rv,
                         logic [63:0] pd, logic ordy);
        ctx_req       = req;
        ctx_data      = cd;
        dma_rsp_valid = rv;
        dma_rsp_pd    = pd;
        out_ready     = ordy;
    endtask

    logic [4:0] e_idx;

    initial begin
        tests = 0;
        fails = 0;
        reset_ = 1'b0;
        drive(1'b0, 11'd0, 1'b0, 64'd0, 1'b1);

        // Reset state
        #3;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_pd", out_pd, 64'd0);
        chk("rst_out_idx", {59'd0, out_idx}, 64'd0);
        chk("rst_last_eol", {62'd0, out_last, out_eol}, 64'd0);
        chk("rst_orphan", {63'd0, orphan_err}, 64'd0);
        chk("rst_ctx_ready", {63'd0, ctx_ready}, 64'd1);
        chk("rst_rsp_ready", {63'd0, dma_rsp_ready}, 64'd0);
        @(negedge clk);
        reset_ = 1'b1;

        // Single context {1,3,2}: idx 2..5, last/eol on 4th beat
        vt.push_back(mk(1, cdat(1, 3, 2), 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 64'hA0, 1, 0, 1, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 64'hA1, 1, 0, 1, 1, 2, 0, 0, 64'hA0));
        vt.push_back(mk(0, 0, 1, 64'hA2, 1, 0, 1, 1, 3, 0, 0, 64'hA1));
        vt.push_back(mk(0, 0, 1, 64'hA3, 1, 1, 1, 1, 4, 0, 0, 64'hA2));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 5, 1, 1, 64'hA3));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        // Back-to-back {0,0,7} then {0,1,30}
        vt.push_back(mk(1, cdat(0, 0, 7), 1, 64'hDEAD, 1, 1, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, cdat(0, 1, 30), 1, 64'hB0, 1, 1, 1, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 64'hB1, 1, 0, 1, 1, 7, 1, 0, 64'hB0));
        vt.push_back(mk(0, 0, 1, 64'hB2, 1, 1, 1, 1, 30, 0, 0, 64'hB1));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 31, 1, 0, 64'hB2));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        // Backpressure: out_ready low 5 cycles with C0 held
        vt.push_back(mk(1, cdat(0, 2, 10), 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 64'hC0, 1, 0, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            vt.push_back(mk(0, 0, 1, 64'hC1, 0, 0, 0, 1, 10, 0, 0, 64'hC0));
        vt.push_back(mk(0, 0, 1, 64'hC1, 1, 0, 1, 1, 10, 0, 0, 64'hC0));
        vt.push_back(mk(0, 0, 1, 64'hC2, 1, 1, 1, 1, 11, 0, 0, 64'hC1));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 12, 1, 0, 64'hC2));
        vt.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));

        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].req, vt[i].cd, vt[i].rv, vt[i].pd, vt[i].ordy);
            #4;
            chk($sformatf("v%0d_ctx_ready", i), {63'd0, ctx_ready}, {63'd0, vt[i].e_cr});
            chk($sformatf("v%0d_rsp_ready", i), {63'd0, dma_rsp_ready}, {63'd0, vt[i].e_rr});
            chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vt[i].e_ov});
            if (vt[i].e_ov) begin
                chk($sformatf("v%0d_out_idx", i), {59'd0, out_idx}, {59'd0, vt[i].e_idx});
                chk($sformatf("v%0d_out_last", i), {63'd0, out_last}, {63'd0, vt[i].e_last});
                chk($sformatf("v%0d_out_eol", i), {63'd0, out_eol}, {63'd0, vt[i].e_eol});
                chk($sformatf("v%0d_out_pd", i), out_pd, vt[i].e_pd);
            end
        end

        // Wrap: {0,31,31} with 32 beats -> idx 31,0..30
        @(negedge clk);
        drive(1'b1, cdat(1'b0, 5'd31, 5'd31), 1'b0, 64'd0, 1'b1);
        #4;
        chk("wrap_pop", {63'd0, ctx_ready}, 64'd1);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            drive(1'b0, 11'd0, 1'b1, 64'(k + 256), 1'b1);
            #4;
            chk($sformatf("wrap%0d_rr", k), {63'd0, dma_rsp_ready}, 64'd1);
            chk($sformatf("wrap%0d_cr", k), {63'd0, ctx_ready}, {63'd0, k == 31});
            if (k > 0) begin
                e_idx = 5'(k + 30);
                chk($sformatf("wrap%0d_idx", k), {59'd0, out_idx}, {59'd0, e_idx});
                chk($sformatf("wrap%0d_last", k), {63'd0, out_last}, 64'd0);
                chk($sformatf("wrap%0d_pd", k), out_pd, 64'(k + 255));
            end
        end
        @(negedge clk);
        drive(1'b0, 11'd0, 1'b0, 64'd0, 1'b1);
        #4;
        chk("wrap_end_valid", {63'd0, out_valid}, 64'd1);
        chk("wrap_end_idx", {59'd0, out_idx}, 64'd30);
        chk("wrap_end_last", {63'd0, out_last}, 64'd1);
        chk("wrap_end_pd", out_pd, 64'd287);

        // Reset after 2 of 4 beats
        @(negedge clk);
        drive(1'b1, cdat(1'b1, 5'd3, 5'd5), 1'b0, 64'd0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1'b0, 11'd0, 1'b1, 64'(k + 64'hE0), 1'b1);
        end
        @(negedge clk);
        drive(1'b0, 11'd0, 1'b1, 64'hE2, 1'b1);
        #1;
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        chk("pre_rst_idx", {59'd0, out_idx}, 64'd6);
        #1;
        reset_ = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_pd", out_pd, 64'd0);
        chk("mid_rst_idx", {59'd0, out_idx}, 64'd0);
        chk("mid_rst_ctx_ready", {63'd0, ctx_ready}, 64'd1);
        chk("mid_rst_rsp_ready", {63'd0, dma_rsp_ready}, 64'd0);
        @(negedge clk);
        reset_ = 1'b1;
        drive(1'b1, cdat(1'b0, 5'd1, 5'd20), 1'b0, 64'd0, 1'b1);
        #4;
        chk("post_rst_pop", {63'd0, ctx_ready}, 64'd1);
        @(negedge clk);
        drive(1'b0, 11'd0, 1'b1, 64'hF0, 1'b1);
        @(negedge clk);
        drive(1'b0, 11'd0, 1'b1, 64'hF1, 1'b1);
        #4;
        chk("post_rst_idx0", {59'd0, out_idx}, 64'd20);
        chk("post_rst_pd0", out_pd, 64'hF0);
        chk("post_rst_last0", {63'd0, out_last}, 64'd0);
        @(negedge clk);
        drive(1'b0, 11'd0, 1'b0, 64'd0, 1'b1);
        #4;
        chk("post_rst_idx1", {59'd0, out_idx}, 64'd21);
        chk("post_rst_pd1", out_pd, 64'hF1);
        chk("post_rst_last1", {63'd0, out_last}, 64'd1);

        // Orphan responses: valid with no context for 20 cycles
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(1'b0, 11'd0, 1'b1, 64'h55, 1'b1);
        end
        #4;
`ifdef NVDLA_CDMA_IMG_RSP_ORPHAN_CHK_EN
        chk("orphan_set", {63'd0, orphan_err}, 64'd1);
`else
        chk("orphan_off", {63'd0, orphan_err}, 64'd0);
`endif
        @(negedge clk);
        drive(1'b1, cdat(1'b0, 5'd0, 5'd0), 1'b1, 64'h55, 1'b1);
        @(negedge clk);
        drive(1'b0, 11'd0, 1'b1, 64'h55, 1'b1);
        @(negedge clk);
        drive(1'b0, 11'd0, 1'b0, 64'd0, 1'b1);
        #4;
        chk("orphan_ctx_beat", {63'd0, out_valid}, 64'd1);
`ifdef NVDLA_CDMA_IMG_RSP_ORPHAN_CHK_EN
        chk("orphan_hold", {63'd0, orphan_err}, 64'd1);
`else
        chk("orphan_hold_off", {63'd0, orphan_err}, 64'd0);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_cdma_img_rsp_unpack.md
# nv_nvdla_cdma_img_rsp_unpack

Read-side consumer for the CDMA image request-context FIFO. It pops 11-bit request contexts, pairs each context with the matching number of DMA read-response beats, and forwards every beat through a registered output stage tagged with an atom index, a last-of-context flag and an end-of-line flag. It sits between the context FIFO read port, the DMA response path and the image packer.

## Interface
- DW, 64, response/output payload width in bits
- ORPHAN_TO, 16, idle cycles with a pending response and no context before the orphan error is flagged (used only with the macro)
- clk  input  1  clock
- reset_  input  1  asynchronous active-low reset
- ctx_req  input  1  context valid; driven by the FIFO rd_req
- ctx_ready  output  1  context pop; drives the FIFO rd_ready
- ctx_data  input  11  [10] eol, [9:5] nbeat_m1, [4:0] start_idx
- dma_rsp_valid  input  1  response beat valid
- dma_rsp_ready  output  1  response beat accept
- dma_rsp_pd  input  DW  response beat data
- out_valid  output  1  tagged beat valid
- out_ready  input  1  downstream accept
- out_pd  output  DW  beat data
- out_idx  output  5  atom index of the beat
- out_last  output  1  final beat of its context
- out_eol  output  1  final beat of a context whose eol bit is 1
- orphan_err  output  1  sticky orphan-response error

## Operation
- State: IDLE or ACTIVE. Context registers: eol_r, nbeat_m1_r, start_idx_r. Counter: beat_cnt[4:0].
- Response accept: rsp_acc = dma_rsp_valid && dma_rsp_ready.
- Last-beat accept: last_acc = rsp_acc && beat_cnt == nbeat_m1_r.
- Context pop, combinational: ctx_ready = (state == IDLE) || last_acc. A pop happens when ctx_req && ctx_ready.
- On a pop:
  - Load the context registers from ctx_data.
  - beat_cnt <= 0.
  - state <= ACTIVE.
- Transition ACTIVE -> IDLE on last_acc with no pop in the same cycle.
- Back-to-back contexts: last_acc together with a pop keeps the state ACTIVE with zero bubble.
- dma_rsp_ready = (state == ACTIVE) && (!out_valid || out_ready). Responses are never accepted in IDLE.
- On each rsp_acc:
  - out_pd <= dma_rsp_pd.
  - out_idx <= start_idx_r + beat_cnt, modulo 32 (5-bit wrap).
  - out_last <= (beat_cnt == nbeat_m1_r).
  - out_eol <= eol_r && (beat_cnt == nbeat_m1_r).
  - beat_cnt <= beat_cnt + 1.
- Output register:
  - Set out_valid on rsp_acc.
  - Clear out_valid on out_ready with no rsp_acc.
  - Payload holds while out_valid && !out_ready.
- Each context produces exactly nbeat_m1 + 1 output beats (1..32).

## Timing
- Reset values:
  - All outputs are 0: out_valid, out_pd, out_idx, out_last, out_eol, orphan_err.
  - ctx_ready is 1 (IDLE). dma_rsp_ready is 0.
  - beat_cnt is 0.
- The context pops in cycle N. The first response can be accepted in cycle N+1.
- Latency: a response accepted in cycle N appears on out_* in cycle N+1.
- Throughput: 1 beat/cycle while out_ready stays high.
- Backpressure: out_valid && !out_ready drops dma_rsp_ready in the same cycle.
- nbeat_m1 = 31 with start_idx = 31: out_idx runs 31, 0, 1 … 30.
- Reset mid-context: all context state is discarded. The block resumes in IDLE, and partially delivered beats are not replayed.

## Configuration
- NVDLA_CDMA_IMG_RSP_ORPHAN_CHK_EN
- Defined:
  - A 5-bit idle counter increments each cycle that state == IDLE && dma_rsp_valid && !ctx_req.
  - It clears on any other cycle.
  - When it reaches ORPHAN_TO, orphan_err sets and holds until reset.
  - Data flow is unaffected.
- Undefined: no counter is built, and orphan_err is tied to 0.

## Test plan
- Single context ctx_data = {1'b1, 5'd3, 5'd2} with 4 responses and out_ready = 1 -> out_idx 2, 3, 4, 5; out_last and out_eol = 1 on the 4th beat only; state returns to IDLE.
- Two contexts queued ({0, 5'd0, 5'd7} then {0, 5'd1, 5'd30}) with continuous responses -> beats idx 7 | 30, 31 with no idle cycle; ctx_ready pulses on the beat with idx 7.
- Wrap: context {0, 5'd31, 5'd31} with 32 responses -> out_idx sequence 31, 0 … 30; out_last only on beat 32.
- Backpressure: out_ready low for 5 cycles mid-context -> dma_rsp_ready low in those cycles; out_pd and out_idx stable; no beat lost or duplicated.
- Reset asserted after 2 of 4 beats -> all outputs 0 and ctx_ready = 1 immediately; a new context afterwards starts at its own start_idx.
- With the macro: dma_rsp_valid = 1, ctx_req = 0 for 16 cycles -> orphan_err = 1 and remains 1 after a context arrives. Without the macro: orphan_err = 0.
